// File: rtl/reg_select_encode_seq.sv
// Register select-and-encode unit: decodes Ra/Rb/Rc fields of the latched instruction into
// one-hot register enables, sign-extends the C constant, and sequences multi-register masks.
module reg_select_encode_seq #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RA_LSB   = 23,
  parameter int unsigned RB_LSB   = 19,
  parameter int unsigned RC_LSB   = 15,
  parameter int unsigned C_W      = 19,
  localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                clear,
  input  logic [DATA_W-1:0]   IR,
  input  logic                ir_load,
  input  logic                Gra,
  input  logic                Grb,
  input  logic                Grc,
  input  logic                Rin,
  input  logic                Rout,
  input  logic                BAout,
  input  logic                lm_start,
  input  logic                lm_dir,
  input  logic                lm_step,
  output logic [NUM_REGS-1:0] RegIn,
  output logic [NUM_REGS-1:0] RegOut,
  output logic [DATA_W-1:0]   C_sign_extended,
  output logic                ba_zero,
  output logic                sel_err,
  output logic                lm_busy,
  output logic                lm_done,
  output logic [SEL_W-1:0]    lm_idx
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [NUM_REGS-1:0] One = {{(NUM_REGS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic                dir_q, dir_d;

  logic [SEL_W-1:0]    sel;
  logic                any_strobe;
  logic                multi_strobe;
  logic [NUM_REGS-1:0] sel_onehot;
  logic [NUM_REGS-1:0] idx_onehot;

  // Instruction capture is frozen while a sequence owns the mask.
  assign ir_d = (ir_load && (state_q == StIdle)) ? IR : ir_q;

  assign C_sign_extended = {{(DATA_W-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

  always_comb begin
    if (Gra)      sel = ir_q[RA_LSB +: SEL_W];
    else if (Grb) sel = ir_q[RB_LSB +: SEL_W];
    else          sel = ir_q[RC_LSB +: SEL_W];
  end

  assign any_strobe   = Gra | Grb | Grc;
  assign multi_strobe = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
  assign sel_onehot   = any_strobe ? (One << sel) : '0;

  // Lowest set bit wins: scan from the top so the last assignment is the lowest index.
  always_comb begin
    lm_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_q[i]) lm_idx = SEL_W'(i);
    end
  end

  assign idx_onehot = One << lm_idx;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dir_d   = dir_q;
    RegIn   = '0;
    RegOut  = '0;
    sel_err = 1'b0;
    ba_zero = 1'b0;
    lm_busy = 1'b0;
    lm_done = 1'b0;
    case (state_q)
      StIdle: begin
        RegIn   = sel_onehot & {NUM_REGS{Rin}};
        RegOut  = sel_onehot & {NUM_REGS{Rout | BAout}};
        sel_err = multi_strobe;
        ba_zero = BAout & any_strobe & (sel == '0);
        if (lm_start) begin
          mask_d  = ir_q[NUM_REGS-1:0];
          dir_d   = lm_dir;
          state_d = (ir_q[NUM_REGS-1:0] == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        lm_busy = 1'b1;
        if (dir_q) RegIn  = idx_onehot;
        else       RegOut = idx_onehot;
        if (lm_step) begin
          mask_d = mask_q & ~idx_onehot;
          if (mask_d == '0) state_d = StDone;
        end
      end
      StDone: begin
        lm_busy = 1'b1;
        lm_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      ir_q    <= '0;
      mask_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      mask_q  <= mask_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: doc/reg_select_encode_seq.md
# reg_select_encode_seq

Parametrised register select-and-encode unit for the datapath control path. It latches the instruction word and decodes the Ra/Rb/Rc fields into one-hot register-enable vectors for the register file. It also produces the sign-extended C constant. A built-in multi-register sequencer walks a register mask one register per control step, for push/pop-multiple style instructions.

## Interface
- NUM_REGS, 16: registers addressed; power of two, 2..32; SEL_W = log2(NUM_REGS)
- DATA_W, 32: instruction and constant width
- RA_LSB, 23: LSB of Ra field (SEL_W bits)
- RB_LSB, 19: LSB of Rb field
- RC_LSB, 15: LSB of Rc field
- C_W, 19: width of C constant field at IR[C_W-1:0]; sign bit IR[C_W-1]; C_W < DATA_W

Ports:
- clk  in  1  clock, rising edge
- clear  in  1  asynchronous, active-low reset
- IR  in  DATA_W  instruction word
- ir_load  in  1  capture IR into ir_q
- Gra, Grb, Grc  in  1 each  field select strobes
- Rin, Rout, BAout  in  1 each  register write / read / base-address read
- lm_start  in  1  start multi-register sequence
- lm_dir  in  1  sampled at lm_start; 1 = load (drive RegIn), 0 = store (drive RegOut)
- lm_step  in  1  control unit consumed current register; advance
- RegIn  out  NUM_REGS  one-hot register write enables
- RegOut  out  NUM_REGS  one-hot register read enables
- C_sign_extended  out  DATA_W  sign-extended ir_q[C_W-1:0]
- ba_zero  out  1  BAout selects R0; bus must carry 0
- sel_err  out  1  more than one of Gra/Grb/Grc asserted
- lm_busy  out  1  sequencer active
- lm_done  out  1  one-cycle completion pulse
- lm_idx  out  SEL_W  register index currently driven by sequencer

## Operation
- ir_q: DATA_W register; loads IR on ir_load when not lm_busy; ir_load while lm_busy is ignored. All decode uses ir_q, never IR directly.
- Single mode (sequencer IDLE):
  - sel = Ra if Gra, else Rb if Grb, else Rc if Grc. Priority is Gra > Grb > Grc.
  - sel_err = 1 when two or more strobes are asserted.
  - No strobe: onehot = 0. Otherwise onehot = 1 << sel.
  - RegIn = onehot & Rin. RegOut = onehot & (Rout | BAout).
  - ba_zero = BAout & (sel == 0) & (at least one strobe asserted).
- C_sign_extended = {(DATA_W-C_W){ir_q[C_W-1]}, ir_q[C_W-1:0]}. It is valid in every state.
- Sequencer FSM:
  - IDLE: on lm_start, latch mask_q = ir_q[NUM_REGS-1:0] and dir_q = lm_dir.
    - mask_q == 0: go to DONE.
    - Otherwise: go to RUN.
  - RUN: lm_idx = index of lowest set bit of mask_q. The vector 1 << lm_idx goes on RegIn if dir_q = 1, or on RegOut if dir_q = 0; the other vector is 0.
    - Gra/Grb/Grc/Rin/Rout/BAout are ignored; sel_err = 0 and ba_zero = 0.
    - On lm_step, clear bit lm_idx in mask_q. If that leaves mask_q == 0, go to DONE; otherwise stay in RUN.
  - DONE: lm_done = 1 for exactly one cycle; RegIn = RegOut = 0; go to IDLE.
- lm_busy = 1 in RUN and DONE. lm_start outside IDLE is ignored.

## Timing
- Reset (clear low, asynchronous): ir_q = 0, mask_q = 0, dir_q = 0, FSM = IDLE. Resulting outputs:
  - RegIn = 0, RegOut = 0, C_sign_extended = 0.
  - ba_zero = 0, sel_err = 0, lm_busy = 0, lm_done = 0, lm_idx = 0.
- Reset asserted mid-sequence aborts with no lm_done pulse.
- Single mode is combinational from strobes and ir_q: enables are valid in the same cycle as the strobes.
- ir_q updates on the edge after ir_load. Decode reflects the new IR from the following cycle.
- lm_start at edge N:
  - RUN from N+1; first register driven in cycle N+1.
  - Each lm_step edge advances by one register.
  - k set bits with lm_step held high: DONE in cycle N+1+k, IDLE in N+2+k.
  - Empty mask: DONE in N+1, IDLE in N+2.
- No lm_step: the current register stays driven indefinitely (stall).
- lm_step in IDLE or DONE has no effect.
- In RUN, exactly one bit of RegIn|RegOut is set. It only changes on an lm_step edge.

## Test plan
- Reset then single mode, NUM_REGS=16:
  - Stimulus: load IR = 0x0A9A_0000 (Ra=5, Rb=3, Rc=4); Gra=1, Rin=1.
  - Required: RegIn = 0x0020, RegOut = 0. Then Grb=1 with Rout=1 gives RegOut = 0x0008.
- Priority and error:
  - Stimulus: Gra=Grc=1, Rout=1.
  - Required: RegOut = 1 << Ra, sel_err = 1. Then Ra=0 with BAout=1 gives RegOut = 0x0001, ba_zero = 1.
- Sign extension:
  - IR[18:0] = 0x40000 gives C_sign_extended = 0xFFFC_0000.
  - IR[18:0] = 0x3FFFF gives 0x0003_FFFF.
  - Check once with C_W=19, DATA_W=32 and once with C_W=12.
- Multi load:
  - Stimulus: mask 0x8121, lm_dir=1, lm_step held high.
  - Required: RegIn sequence 0x0001, 0x0020, 0x0100, 0x8000; lm_idx sequence 0, 5, 8, 15; lm_done in the 5th cycle after lm_start; strobes ignored throughout.
- Stall and boundaries:
  - Mask 0 gives lm_done one cycle after lm_start with no enables driven.
  - Mask 0x0004 with lm_step low for 3 cycles keeps RegOut = 0x0004 held.
  - ir_load during RUN leaves ir_q unchanged.
  - lm_start during RUN is ignored.
- Reset mid-sequence:
  - Stimulus: clear low asynchronously in the 2nd RUN cycle.
  - Required: RegIn, RegOut and lm_busy go to 0 immediately; no lm_done pulse; after release the unit is IDLE and accepts a new lm_start.
